// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: sequential word fetches into a DEPTH-entry FIFO feeding decode.
// Optional macro IF_BYPASS_EN forwards a returning fetch straight to decode when the queue is empty.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {RUN, DISCARD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, req_addr;
    logic [PW:0]   count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic q_empty, q_full, push, pop, bypass, wr_en, abandon;
    logic [1:0] unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    assign q_empty   = (count == '0);
    assign q_full    = (count == FULL_CNT);
    // Room never shrinks while a request waits, so !q_full alone keeps the request held.
    assign imem_req  = reset && ((state == DISCARD) || !q_full);
    assign imem_addr = (state == DISCARD) ? req_addr : fetch_pc;

    assign push    = (state == RUN) && imem_req && imem_ack && !redirect;
    assign pop     = !q_empty && !stall && !redirect;
    assign abandon = (state == RUN) && imem_req && !imem_ack;

`ifdef IF_BYPASS_EN
    assign bypass = reset && (state == RUN) && q_empty && imem_ack;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed fetch that decode takes this cycle never occupies a slot.
    assign wr_en     = push && !(bypass && !stall);
    assign out_valid = !q_empty || bypass;

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        if (!q_empty) begin
            out_inst = inst_mem[rd_ptr];
            out_pc   = pc_mem[rd_ptr];
        end else if (bypass) begin
            out_inst = imem_data;
            out_pc   = fetch_pc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (redirect && abandon) state_nxt = DISCARD;
            DISCARD: if (!redirect && imem_ack) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            req_addr <= {RESET_PC[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (abandon) req_addr <= fetch_pc;
        end else begin
            if (push)  fetch_pc <= fetch_pc + 32'd4;
            if (wr_en) wr_ptr   <= wr_ptr + PW'(1);
            if (pop)   rd_ptr   <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries data only; validity lives in count.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            inst_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

endmodule
